tl_req_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single L1 adapter command port of tl_top between N_REQ independent requesters.
- Accepts one request at a time and assigns it a TileLink source ID.
- Pulses start_transaction, waits for transaction_done with a timeout, then returns read data and a status to the winning requester.
- Sits between the CPU-side request masters and tl_top.

---
 rtl/tl_req_arbiter_pkg.sv | 33 +++
 rtl/tl_rr_picker.sv | 33 +++
 rtl/tl_req_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_tl_req_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_req_arbiter_pkg.sv
// Shared widths, command/status encodings and FSM state type for the
// tl_top request arbiter slice.
package tl_req_arbiter_pkg;

  localparam int unsigned TL_ADDR_BITS   = 32;
  localparam int unsigned TL_SIZE_BITS   = 3;
  localparam int unsigned TL_SOURCE_BITS = 4;
  localparam int unsigned TL_DATA_BYTES  = 8;
  localparam int unsigned TL_DATA_BITS   = TL_DATA_BYTES * 8;
  localparam int unsigned REQ_IDX_BITS   = 3;

  localparam logic [1:0] TX_GET        = 2'b00;
  localparam logic [1:0] TX_PUTFULL    = 2'b01;
  localparam logic [1:0] TX_PUTPARTIAL = 2'b10;
  localparam logic [1:0] TX_RESERVED   = 2'b11;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_TIMEOUT = 2'b01;
  localparam logic [1:0] RSP_BADTYPE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  // Successor of requester index g in an n-entry ring.
  function automatic logic [REQ_IDX_BITS-1:0] rr_next(input logic [REQ_IDX_BITS-1:0] g,
                                                      input int unsigned n);
    return (32'(g) + 32'd1 >= n) ? '0 : g + REQ_IDX_BITS'(1);
  endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// Combinational round-robin search: first set req_valid bit at or after
// rr_ptr, wrapping modulo N_REQ.
module tl_rr_picker
  import tl_req_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [REQ_IDX_BITS-1:0] rr_ptr,
  output logic [N_REQ-1:0]        grant,
  output logic [REQ_IDX_BITS-1:0] grant_idx,
  output logic                    grant_any
);

  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // rr_ptr < N_REQ, so one conditional subtract replaces a modulo
      idx = 32'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = REQ_IDX_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/tl_req_arbiter.sv
// Round-robin arbiter/sequencer sharing the single tl_top command port
// between N_REQ requesters; one transaction in flight at a time.
module tl_req_arbiter
  import tl_req_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned SOURCE_BASE = 1,
  parameter int unsigned TIMEOUT     = 100
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [2*N_REQ-1:0]             req_type,
  input  logic [N_REQ*TL_ADDR_BITS-1:0]  req_addr,
  input  logic [N_REQ*TL_SIZE_BITS-1:0]  req_size,
  input  logic [N_REQ*TL_DATA_BITS-1:0]  req_wdata,
  input  logic [N_REQ*TL_DATA_BYTES-1:0] req_wmask,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [1:0]                     rsp_status,
  output logic [TL_DATA_BITS-1:0]        rsp_rdata,
  output logic                           start_transaction,
  output logic [1:0]                     transaction_type,
  output logic [TL_ADDR_BITS-1:0]        address,
  output logic [TL_SIZE_BITS-1:0]        size,
  output logic [TL_SOURCE_BITS-1:0]      source,
  output logic [TL_DATA_BITS-1:0]        write_data,
  output logic [TL_DATA_BYTES-1:0]       write_mask,
  input  logic                           transaction_done,
  input  logic [TL_DATA_BITS-1:0]        read_data,
  output logic                           busy,
  output logic [REQ_IDX_BITS-1:0]        grant_id
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  arb_state_e                 state_q, state_d;
  logic [REQ_IDX_BITS-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]                 cnt_q, cnt_d;

  logic                       start_d;
  logic [N_REQ-1:0]           rsp_valid_d;
  logic [1:0]                 rsp_status_d;
  logic [TL_DATA_BITS-1:0]    rsp_rdata_d;
  logic [1:0]                 type_d;
  logic [TL_ADDR_BITS-1:0]    addr_d;
  logic [TL_SIZE_BITS-1:0]    size_d;
  logic [TL_SOURCE_BITS-1:0]  source_d;
  logic [TL_DATA_BITS-1:0]    wdata_d;
  logic [TL_DATA_BYTES-1:0]   wmask_d;
  logic [REQ_IDX_BITS-1:0]    grant_id_d;

  logic [N_REQ-1:0]           pick_grant;
  logic [REQ_IDX_BITS-1:0]    pick_idx;
  logic                       pick_any;

  logic [1:0]                 sel_type;
  logic [TL_ADDR_BITS-1:0]    sel_addr;
  logic [TL_SIZE_BITS-1:0]    sel_size;
  logic [TL_DATA_BITS-1:0]    sel_wdata;
  logic [TL_DATA_BYTES-1:0]   sel_wmask;

  tl_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  assign req_ready = (state_q == ST_IDLE) ? pick_grant : '0;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    sel_type  = '0;
    sel_addr  = '0;
    sel_size  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_type  = req_type[2*i +: 2];
        sel_addr  = req_addr[i*TL_ADDR_BITS +: TL_ADDR_BITS];
        sel_size  = req_size[i*TL_SIZE_BITS +: TL_SIZE_BITS];
        sel_wdata = req_wdata[i*TL_DATA_BITS +: TL_DATA_BITS];
        sel_wmask = req_wmask[i*TL_DATA_BYTES +: TL_DATA_BYTES];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    start_d      = 1'b0;
    rsp_valid_d  = '0;
    rsp_status_d = rsp_status;
    rsp_rdata_d  = rsp_rdata;
    type_d       = transaction_type;
    addr_d       = address;
    size_d       = size;
    source_d     = source;
    wdata_d      = write_data;
    wmask_d      = write_mask;
    grant_id_d   = grant_id;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          type_d     = sel_type;
          addr_d     = sel_addr;
          size_d     = sel_size;
          wdata_d    = sel_wdata;
          wmask_d    = sel_wmask;
          source_d   = TL_SOURCE_BITS'(SOURCE_BASE + 32'(pick_idx));
          grant_id_d = pick_idx;
          rr_ptr_d   = rr_next(pick_idx, N_REQ);
          if (sel_type == TX_RESERVED) begin
            rsp_status_d = RSP_BADTYPE;
            rsp_rdata_d  = '0;
            rsp_valid_d  = pick_grant;
            state_d      = ST_RESP;
          end else begin
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Nothing is sampled or counted during the start cycle, so a
        // timeout strobe lands TIMEOUT+1 cycles after start_transaction.
        if (!start_transaction) begin
          if (transaction_done || cnt_q == TIMEOUT_LAST) begin
            for (int unsigned i = 0; i < N_REQ; i++)
              if (grant_id == REQ_IDX_BITS'(i)) rsp_valid_d[i] = 1'b1;
            state_d = ST_RESP;
            if (transaction_done) begin
              rsp_status_d = RSP_OK;
              rsp_rdata_d  = (transaction_type == TX_GET) ? read_data : '0;
            end else begin
              rsp_status_d = RSP_TIMEOUT;
              rsp_rdata_d  = '0;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      rr_ptr_q          <= '0;
      cnt_q             <= '0;
      start_transaction <= 1'b0;
      rsp_valid         <= '0;
      rsp_status        <= RSP_OK;
      rsp_rdata         <= '0;
      transaction_type  <= TX_GET;
      address           <= '0;
      size              <= TL_SIZE_BITS'(3);
      source            <= '0;
      write_data        <= '0;
      write_mask        <= '1;
      grant_id          <= '0;
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      cnt_q             <= cnt_d;
      start_transaction <= start_d;
      rsp_valid         <= rsp_valid_d;
      rsp_status        <= rsp_status_d;
      rsp_rdata         <= rsp_rdata_d;
      transaction_type  <= type_d;
      address           <= addr_d;
      size              <= size_d;
      source            <= source_d;
      write_data        <= wdata_d;
      write_mask        <= wmask_d;
      grant_id          <= grant_id_d;
    end
  end

endmodule

// File: tb/tb_tl_req_arbiter.sv
// Self-checking bench for tl_req_arbiter: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tl_req_arbiter;
  import tl_req_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int SB = 1;
  localparam int TO = 12;
  localparam int AB = TL_ADDR_BITS;
  localparam int ZB = TL_SIZE_BITS;
  localparam int DB = TL_DATA_BITS;
  localparam int MB = TL_DATA_BYTES;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [2*N-1:0]  req_type;
  logic [N*AB-1:0] req_addr;
  logic [N*ZB-1:0] req_size;
  logic [N*DB-1:0] req_wdata;
  logic [N*MB-1:0] req_wmask;
  logic [1:0]      rsp_status, transaction_type;
  logic [DB-1:0]   rsp_rdata, write_data, read_data;
  logic            start_transaction, transaction_done, busy;
  logic [AB-1:0]   address;
  logic [ZB-1:0]   size;
  logic [TL_SOURCE_BITS-1:0] source;
  logic [MB-1:0]   write_mask;
  logic [2:0]      grant_id;

  tl_req_arbiter #(.N_REQ(N), .SOURCE_BASE(SB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_size(req_size),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
    .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .start_transaction(start_transaction), .transaction_type(transaction_type),
    .address(address), .size(size), .source(source), .write_data(write_data),
    .write_mask(write_mask), .transaction_done(transaction_done),
    .read_data(read_data), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_mode = 2;   // 0 random, 1 always high, 2 always low
  int done_pct  = 0;

  // Transaction-level model: one record for the transaction in flight.
  bit                        m_active, m_bad;
  int                        m_age, m_resp_age, m_g, m_ptr, m_just;
  logic [1:0]                m_type, m_status;
  logic [AB-1:0]             m_addr;
  logic [ZB-1:0]             m_size;
  logic [DB-1:0]             m_wdata, m_rdata;
  logic [MB-1:0]             m_wmask;
  logic [TL_SOURCE_BITS-1:0] m_source;
  logic [DB-1:0]             mem [logic [AB-1:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_bad = 0; m_age = 0; m_resp_age = -1; m_g = 0; m_ptr = 0; m_just = -1;
    m_type = TX_GET; m_addr = '0; m_size = 3'd3; m_wdata = '0; m_wmask = '1;
    m_source = '0; m_status = RSP_OK; m_rdata = '0;
  endtask

  // Advance the model across one rising edge, using the inputs driven before it.
  task automatic model_edge();
    int w;
    logic [DB-1:0] old;
    m_just = -1;
    if (m_active) begin
      m_age++;
      if (m_resp_age < 0 && m_age >= 2) begin
        if (transaction_done) begin
          m_resp_age = m_age; m_status = RSP_OK;
          m_rdata = (m_type == TX_GET) ? read_data : '0;
          if (m_type == TX_PUTFULL) mem[m_addr] = m_wdata;
          if (m_type == TX_PUTPARTIAL) begin
            old = mem.exists(m_addr) ? mem[m_addr] : '0;
            for (int b = 0; b < MB; b++) if (m_wmask[b]) old[b*8 +: 8] = m_wdata[b*8 +: 8];
            mem[m_addr] = old;
          end
        end else if (m_age == TO + 1) begin
          m_resp_age = m_age; m_status = RSP_TIMEOUT; m_rdata = '0;
        end
      end else if (m_resp_age >= 0 && m_age == m_resp_age + 1) begin
        m_active = 0;
      end
    end else begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) begin
        m_active = 1; m_age = 0; m_g = w; m_just = w; m_ptr = (w + 1) % N;
        m_type  = req_type[2*w +: 2];
        m_addr  = req_addr[w*AB +: AB];
        m_size  = req_size[w*ZB +: ZB];
        m_wdata = req_wdata[w*DB +: DB];
        m_wmask = req_wmask[w*MB +: MB];
        m_source = TL_SOURCE_BITS'(SB + w);
        m_bad = (m_type == TX_RESERVED);
        m_resp_age = m_bad ? 0 : -1;
        if (m_bad) begin m_status = RSP_BADTYPE; m_rdata = '0; end
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_rv;
    exp_rv = '0;
    if (m_active && m_age == m_resp_age) exp_rv[m_g] = 1'b1;
    chk("busy", busy, m_active);
    chk("start_transaction", start_transaction, m_active && m_age == 0 && !m_bad);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_status", rsp_status, m_status);
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("grant_id", grant_id, m_g);
    chk("source", source, m_source);
    chk("transaction_type", transaction_type, m_type);
    chk("address", address, m_addr);
    chk("size", size, m_size);
    chk("write_data", write_data, m_wdata);
    chk("write_mask", write_mask, m_wmask);
  endtask

  task automatic drive_adapter();
    case (done_mode)
      0:       transaction_done = ($urandom_range(0, 99) < done_pct);
      1:       transaction_done = 1'b1;
      default: transaction_done = 1'b0;
    endcase
    if (m_active && m_type == TX_GET) read_data = mem.exists(m_addr) ? mem[m_addr] : '0;
    else read_data = {$urandom, $urandom};
  endtask

  // Caller drives requester inputs at a falling edge, then calls this.
  task automatic cycle();
    int w;
    logic [N-1:0] exp_rdy;
    drive_adapter();
    #1;
    w = pick(req_valid, m_ptr);
    exp_rdy = '0;
    if (!m_active && w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_req(input int i, input logic [1:0] t, input logic [AB-1:0] a,
                         input logic [ZB-1:0] s, input logic [DB-1:0] d, input logic [MB-1:0] m);
    req_type[2*i +: 2]   = t;
    req_addr[i*AB +: AB] = a;
    req_size[i*ZB +: ZB] = s;
    req_wdata[i*DB +: DB] = d;
    req_wmask[i*MB +: MB] = m;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    while (m_active && n < 4 * TO) begin cycle(); n++; end
    chk("drain_busy", busy, 1'b0);
  endtask

  task automatic run_req(input int g, input logic [1:0] t, input logic [AB-1:0] a,
                         input logic [DB-1:0] d, output int n_start, output logic [N-1:0] rv,
                         output logic [1:0] st, output logic [DB-1:0] rd,
                         output logic [TL_SOURCE_BITS-1:0] src, output int lat);
    int start_cyc;
    bit fin;
    drain();
    n_start = 0; rv = '0; st = '0; rd = '0; src = '0; lat = -1; start_cyc = -1; fin = 0;
    set_req(g, t, a, 3'd3, d, '1);
    req_valid = '0;
    req_valid[g] = 1'b1;
    for (int cyc = 0; cyc < TO + 20 && !fin; cyc++) begin
      cycle();
      req_valid = '0;
      if (start_transaction) begin n_start++; start_cyc = cyc; src = source; end
      if (rsp_valid != '0) begin rv = rsp_valid; st = rsp_status; rd = rsp_rdata; lat = cyc - start_cyc; end
      if (!m_active) fin = 1;
    end
    chk("run_req_finished", fin, 1'b1);
  endtask

  task automatic apply_reset();
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_st, lat;
    logic [N-1:0] rv;
    logic [1:0] st;
    logic [DB-1:0] rd;
    logic [TL_SOURCE_BITS-1:0] src;
    int order[$];

    rst_n = 1'b0; req_valid = '0; req_type = '0; req_addr = '0; req_size = '0;
    req_wdata = '0; req_wmask = '0; transaction_done = 1'b0; read_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_size", size, 3'd3);
    chk("rst_wmask", write_mask, 8'hFF);
    chk("rst_source", source, 4'd0);
    rst_n = 1'b1;
    check_outputs();

    // Single GET from requester 0; done held high (ignored during start cycle).
    done_mode = 1;
    run_req(0, TX_GET, 32'h1000, '0, n_st, rv, st, rd, src, lat);
    chk("get_source", src, 4'd1);
    chk("get_nstart", n_st, 1);
    chk("get_rsp_valid", rv, 4'b0001);
    chk("get_status", st, 2'b00);
    chk("get_rdata", rd, 64'h0);
    chk("get_latency", lat, 2);

    // PUTFULL by requester 2, then GET by requester 1 of the same address.
    run_req(2, TX_PUTFULL, 32'h2000, 64'h11223344AABBCCDD, n_st, rv, st, rd, src, lat);
    chk("put_source", src, 4'd3);
    chk("put_rsp_valid", rv, 4'b0100);
    chk("put_rdata", rd, 64'h0);
    run_req(1, TX_GET, 32'h2000, '0, n_st, rv, st, rd, src, lat);
    chk("rd_source", src, 4'd2);
    chk("rd_rdata", rd, 64'h11223344AABBCCDD);

    // Fairness from a fresh pointer.
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, TX_GET, 32'h3000 + 32'(8 * i), 3'd3, '0, '1);
    req_valid = '1;
    order = {};
    for (int c = 0; c < 24 && order.size() < 5; c++) begin
      cycle();
      if (start_transaction) order.push_back(int'(source) - SB);
    end
    req_valid = '0;
    chk("fair_count", order.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < order.size()) chk($sformatf("fair_grant%0d", k), order[k], k % N);
    drain();

    // Reserved type.
    run_req(3, TX_RESERVED, 32'h0, '0, n_st, rv, st, rd, src, lat);
    chk("bad_nstart", n_st, 0);
    chk("bad_rsp_valid", rv, 4'b1000);
    chk("bad_status", st, 2'b10);
    chk("bad_rdata", rd, 64'h0);
    chk("bad_latency", lat, 1);

    // Timeout, then a late done is ignored and the next request proceeds.
    done_mode = 2;
    run_req(0, TX_GET, 32'h2000, '0, n_st, rv, st, rd, src, lat);
    chk("to_status", st, 2'b01);
    chk("to_latency", lat, TO + 1);
    chk("to_rdata", rd, 64'h0);
    chk("to_rsp_valid", rv, 4'b0001);
    done_mode = 1;
    repeat (3) cycle();
    run_req(1, TX_GET, 32'h2000, '0, n_st, rv, st, rd, src, lat);
    chk("post_to_status", st, 2'b00);
    chk("post_to_rdata", rd, 64'h11223344AABBCCDD);

    // Asynchronous reset while waiting on the adapter.
    drain();
    done_mode = 2;
    set_req(2, TX_GET, 32'h2000, 3'd3, '0, '1);
    req_valid = '0;
    req_valid[2] = 1'b1;
    cycle();
    req_valid = '0;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_start", start_transaction, 1'b0);
    chk("arst_rsp_valid", rsp_valid, 4'b0000);
    chk("arst_size", size, 3'd3);
    chk("arst_wmask", write_mask, 8'hFF);
    chk("arst_source", source, 4'd0);
    chk("arst_address", address, 32'h0);
    model_reset();
    transaction_done = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    done_mode = 1;
    repeat (3) cycle();
    run_req(2, TX_GET, 32'h2000, '0, n_st, rv, st, rd, src, lat);
    chk("arst_get_status", st, 2'b00);
    chk("arst_get_rv", rv, 4'b0100);
    chk("arst_get_rdata", rd, 64'h11223344AABBCCDD);

    // Randomized traffic with stray/late dones and timeout-heavy windows.
    for (int k = 0; k < 8; k++) mem[32'h4000 + 32'(8 * k)] = {$urandom, $urandom};
    done_mode = 0;
    for (int c = 0; c < 1500; c++) begin
      done_pct = ((c / 100) % 5 == 4) ? 0 : 35;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            set_req(i, 2'($urandom_range(0, 3)), 32'h4000 + 32'(8 * $urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom));
          end
        end else if ($urandom_range(0, 39) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      cycle();
      if (m_just >= 0) req_valid[m_just] = 1'b0;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
